// File: rtl/square_move_ctrl.sv
// rtl/square_move_ctrl.sv - debounced push-button mover for a square sprite, updated once per frame (optional SQUARE_WRAP_EN: wrap at edges instead of saturating)
module square_move_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SQ_SIZE    = 32,
    parameter int STEP       = 8,
    parameter int DEB_CYCLES = 125000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       iVS,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oMOVED
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]      DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - SQ_SIZE);
    localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_H - SQ_SIZE);
    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic [9:0]         X_RST    = 10'((SCREEN_W - SQ_SIZE) / 2);
    localparam logic [8:0]         Y_RST    = 9'((SCREEN_H - SQ_SIZE) / 2);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t        state, state_next;
    logic [3:0]    btn_raw;
    logic [3:0]    sync_q1, sync_q2;
    logic [3:0]    deb;
    logic [CW-1:0] deb_cnt [4];
    logic [3:0]    deb_hit, deb_rise;
    logic [3:0]    pending;
    logic          vs_prev, frame_start;
    logic signed [11:0] cand_x, cand_y;
    logic [9:0]    next_x;
    logic [8:0]    next_y;

    // Bit order everywhere: [3]=left, [2]=right, [1]=up, [0]=down
    assign btn_raw = {left, right, up, down};

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        deb_hit  = '0;
        deb_rise = '0;
        for (int i = 0; i < 4; i++) begin
            deb_hit[i]  = (sync_q2[i] != deb[i]) && (deb_cnt[i] == DEB_LAST);
            deb_rise[i] = deb_hit[i] && sync_q2[i];
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (deb_hit[i]) begin
                    deb[i]     <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else if (sync_q2[i] != deb[i]) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // A rise landing on the snapshot cycle survives into the next frame
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n)
            pending <= '0;
        else if (state == CALC)
            pending <= deb_rise;
        else
            pending <= pending | deb_rise;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) vs_prev <= 1'b1;
        else         vs_prev <= iVS;
    end

    assign frame_start = vs_prev && !iVS;

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        oMOVED     = 1'b0;
        case (state)
            IDLE:    if (frame_start) state_next = CALC;
            CALC:    state_next = COMMIT;
            COMMIT: begin
                state_next = IDLE;
                oMOVED     = (next_x != oX) || (next_y != oY);
            end
            default: state_next = IDLE;
        endcase
    end

    function automatic logic signed [11:0] bound_pos(input logic signed [11:0] v,
                                                     input logic signed [11:0] vmax);
`ifdef SQUARE_WRAP_EN
        if (v < 12'sd0)  return vmax;
        if (v > vmax)    return 12'sd0;
`else
        if (v < 12'sd0)  return 12'sd0;
        if (v > vmax)    return vmax;
`endif
        return v;
    endfunction

    // Opposing directions cancel; the candidate is taken from the pre-clear pending set
    always_comb begin
        cand_x = $signed({2'b00, oX});
        cand_y = $signed({3'b000, oY});
        if (pending[2] && !pending[3])      cand_x = cand_x + STEP_S;
        else if (pending[3] && !pending[2]) cand_x = cand_x - STEP_S;
        if (pending[0] && !pending[1])      cand_y = cand_y + STEP_S;
        else if (pending[1] && !pending[0]) cand_y = cand_y - STEP_S;
        cand_x = bound_pos(cand_x, X_MAX);
        cand_y = bound_pos(cand_y, Y_MAX);
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            next_x <= X_RST;
            next_y <= Y_RST;
        end else if (state == CALC) begin
            next_x <= 10'(cand_x);
            next_y <= 9'(cand_y);
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oX <= X_RST;
            oY <= Y_RST;
        end else if (state == COMMIT) begin
            oX <= next_x;
            oY <= next_y;
        end
    end

endmodule

// File: tb/tb_square_move_ctrl.sv
// tb/tb_square_move_ctrl.sv - randomized self-checking bench for square_move_ctrl against a frame-level position model
module tb_square_move_ctrl;

    localparam int XMAX = 608;
    localparam int YMAX = 448;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic       vs = 1'b1;
    logic [9:0] ox;
    logic [8:0] oy;
    logic       moved;

    int checks = 0;
    int errors = 0;
    int moved_cnt = 0;
    int ex = 304;
    int ey = 224;

    square_move_ctrl #(.DEB_CYCLES(4)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .left(left), .right(right), .up(up), .down(down),
        .iVS(vs), .oX(ox), .oY(oy), .oMOVED(moved)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (moved === 1'b1) moved_cnt++;

    function automatic int limit(input int v, input int vmax);
`ifdef SQUARE_WRAP_EN
        if (v < 0) return vmax;
        if (v > vmax) return 0;
`else
        if (v < 0) return 0;
        if (v > vmax) return vmax;
`endif
        return v;
    endfunction

    // req bits: [3]=left [2]=right [1]=up [0]=down
    task automatic model_apply(input logic [3:0] req, output logic mv);
        int dx, dy, nx, ny;
        dx = (req[2] == req[3]) ? 0 : (req[2] ? 8 : -8);
        dy = (req[0] == req[1]) ? 0 : (req[0] ? 8 : -8);
        nx = limit(ex + dx, XMAX);
        ny = limit(ey + dy, YMAX);
        mv = (nx != ex) || (ny != ey);
        ex = nx;
        ey = ny;
    endtask

    task automatic press(input logic [3:0] m);
        {left, right, up, down} = m;
        repeat (10) @(negedge clk);
        {left, right, up, down} = 4'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input logic [3:0] req, input string name);
        logic mv;
        int   mc0, old_x, old_y;
        old_x = ex;
        old_y = ey;
        model_apply(req, mv);
        mc0 = moved_cnt;
        vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vs = 1'b1;
        checks++;
        if (moved !== mv || ox !== 10'(old_x) || oy !== 9'(old_y)) begin
            errors++;
            $display("FAIL %s commit: moved=%0b x=%0d y=%0d, required moved=%0b x=%0d y=%0d",
                     name, moved, ox, oy, mv, old_x, old_y);
        end
        @(negedge clk);
        checks++;
        if (ox !== 10'(ex) || oy !== 9'(ey)) begin
            errors++;
            $display("FAIL %s pos: x=%0d y=%0d, required x=%0d y=%0d", name, ox, oy, ex, ey);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (moved_cnt - mc0 != int'(mv)) begin
            errors++;
            $display("FAIL %s pulses: %0d, required %0d", name, moved_cnt - mc0, int'(mv));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ex = 304;
        ey = 224;
        checks++;
        if (ox !== 10'd304 || oy !== 9'd224 || moved !== 1'b0) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d moved=%0b, required 304 224 0", ox, oy, moved);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_idle_frames();
        int mc0;
        mc0 = moved_cnt;
        for (int i = 0; i < 3; i++) do_frame(4'b0000, "idle");
        checks++;
        if (moved_cnt != mc0) begin
            errors++;
            $display("FAIL idle_moved: %0d pulses, required 0", moved_cnt - mc0);
        end
    endtask

    task automatic test_single_right();
        press(4'b0100);
        do_frame(4'b0100, "right");
        checks++;
        if (ox !== 10'd312) begin
            errors++;
            $display("FAIL right_x: %0d, required 312", ox);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            right = 1'b1;
            repeat (3) @(negedge clk);
            right = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        do_frame(4'b0000, "bounce");
    endtask

    task automatic test_cancel_and_up();
        int x0;
        x0 = ex;
        press(4'b1110);
        do_frame(4'b1110, "lr_up");
        checks++;
        if (ox !== 10'(x0) || oy !== 9'd216) begin
            errors++;
            $display("FAIL lr_up: x=%0d y=%0d, required x=%0d y=216", ox, oy, x0);
        end
    endtask

    task automatic test_random();
        logic [3:0] m;
        for (int i = 0; i < 20; i++) begin
            m = 4'($urandom_range(0, 15));
            press(m);
            do_frame(m, "random");
        end
    endtask

    task automatic test_bounds();
        apply_reset();
        for (int i = 0; i < 38; i++) begin
            press(4'b1000);
            do_frame(4'b1000, "left_walk");
        end
        checks++;
        if (ox !== 10'd0) begin
            errors++;
            $display("FAIL left_edge: x=%0d, required 0", ox);
        end
        press(4'b1000);
        do_frame(4'b1000, "past_edge");
        checks++;
`ifdef SQUARE_WRAP_EN
        if (ox !== 10'd608) begin
            errors++;
            $display("FAIL wrap_x: %0d, required 608", ox);
        end
`else
        if (ox !== 10'd0) begin
            errors++;
            $display("FAIL sat_x: %0d, required 0", ox);
        end
`endif
    endtask

    // Right's debounced rise lands exactly on the snapshot edge
    task automatic test_calc_coincide();
        right = 1'b1;
        repeat (4) @(negedge clk);
        do_frame(4'b0000, "coincide_first");
        right = 1'b0;
        repeat (10) @(negedge clk);
        do_frame(4'b0100, "coincide_next");
    endtask

    task automatic test_reset_in_commit();
        press(4'b0001);
        press(4'b0100);
        vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        vs = 1'b1;
        @(negedge clk);
        ex = 304;
        ey = 224;
        checks++;
        if (ox !== 10'd304 || oy !== 9'd224 || moved !== 1'b0) begin
            errors++;
            $display("FAIL commit_reset: x=%0d y=%0d moved=%0b, required 304 224 0", ox, oy, moved);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_frame(4'b0000, "after_reset");
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_single_right();
        test_bounce();
        test_cancel_and_up();
        test_random();
        test_calc_coincide();
        test_bounds();
        test_reset_in_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_move_ctrl.md
SQUARE_MOVE_CTRL -- requirements
Module: square_move_ctrl

Interface
REQ-001 The module SHALL have parameter SCREEN_W, default 640, giving the visible width in pixels.
REQ-002 The module SHALL have parameter SCREEN_H, default 480, giving the visible height in pixels.
REQ-003 The module SHALL have parameter SQ_SIZE, default 32, giving the square edge length in pixels.
REQ-004 The module SHALL have parameter STEP, default 8, giving the pixels moved per accepted press.
REQ-005 The module SHALL have parameter DEB_CYCLES, default 125000 (5 ms at 25 MHz), giving the debounce stability window in cycles.
REQ-006 The module SHALL have port iVGA_CLK, input, 1 bit: the single clock.
REQ-007 The module SHALL have port iRST_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The module SHALL have ports left, right, up, down, input, 1 bit each: raw push-button levels, asynchronous to the clock, active-high.
REQ-009 The module SHALL have port iVS, input, 1 bit: vertical sync from the sync generator, low pulse marking frame start, synchronous to iVGA_CLK.
REQ-010 The module SHALL have port oX, output, 10 bits: square top-left column.
REQ-011 The module SHALL have port oY, output, 9 bits: square top-left row.
REQ-012 The module SHALL have port oMOVED, output, 1 bit: one-cycle pulse when oX or oY changes.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized button SHALL have its own debounce counter; the debounced level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles, and any mismatch gap SHALL restart the count at 0.
REQ-015 A 0->1 transition of a debounced level SHALL set that direction's pending flag; a held button SHALL produce exactly one request (no auto-repeat).
REQ-016 Frame start SHALL be the cycle where iVS is 0 and its registered previous value is 1.
REQ-017 The FSM SHALL have states IDLE, CALC and COMMIT: IDLE->CALC on frame start; CALC->COMMIT unconditionally; COMMIT->IDLE unconditionally.
REQ-018 In CALC, pending flags SHALL be snapshotted and cleared, and the next position SHALL be computed from the snapshot.
REQ-019 A pending flag set in the same cycle as the CALC snapshot SHALL be kept for the next frame, not lost.
REQ-020 Horizontal step rules: right only -> +STEP; left only -> -STEP; both or neither -> no change. Vertical rules are the same with down = +STEP and up = -STEP.
REQ-021 Arithmetic SHALL use signed 12-bit intermediates so that underflow below 0 is detectable.
REQ-022 X SHALL be bounded to [0, SCREEN_W-SQ_SIZE] and Y to [0, SCREEN_H-SQ_SIZE], per the Configuration rules.
REQ-023 oX and oY SHALL update in COMMIT, making them valid 2 cycles after frame start and stable for the rest of the frame.
REQ-024 oMOVED SHALL be 1 for the COMMIT cycle only, and only if the new (X,Y) differs from the old (X,Y).
REQ-025 A frame start seen while not in IDLE SHALL be ignored.

Reset
REQ-026 While iRST_n=0 at a rising edge, the module SHALL load oX=(SCREEN_W-SQ_SIZE)/2 (304) and oY=(SCREEN_H-SQ_SIZE)/2 (224).
REQ-027 The same reset SHALL clear oMOVED to 0, clear all pending flags, set the FSM to IDLE, clear synchronizers, debounced levels and counters to 0, and clear the iVS history register to 1.
REQ-028 A reset asserted mid-CALC or mid-COMMIT SHALL abort the update; no partial position SHALL be committed.

Configuration
REQ-029 With macro SQUARE_WRAP_EN defined, a step past the upper bound SHALL wrap to 0, and a step below 0 SHALL wrap to the upper bound (SCREEN_W-SQ_SIZE or SCREEN_H-SQ_SIZE).
REQ-030 With SQUARE_WRAP_EN undefined, the position SHALL saturate at the bound; at the bound oMOVED SHALL stay 0 if neither axis changes.

Verification (DEB_CYCLES=4 in bench)
REQ-031 Reset, then 3 frames with no buttons -> oX=304, oY=224, oMOVED never 1.
REQ-032 right held high 10 cycles, then 1 frame -> oX=312 two cycles after the iVS falling edge, and oMOVED high for exactly 1 cycle.
REQ-033 right toggles with high periods of 3 cycles (shorter than DEB_CYCLES) -> no pending flag set, oX unchanged.
REQ-034 left and right both pressed before a frame -> oX unchanged; up pressed -> oY=216.
REQ-035 Saturate build, 38 left presses over 38 frames -> oX reaches 0 and stays 0; at that point a further left press leaves oMOVED at 0. Wrap build: from oX=0, left -> oX=608.
REQ-036 right debounced edge coincides with the CALC cycle -> the move is applied in the following frame; iRST_n pulsed low during COMMIT -> oX=304, oY=224.
